// File: rtl/mem_copy_engine_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_engine_pkg
// Shared types for the memory copy/fill engine: the request mode encoding and
// the controller state encoding.
// -----------------------------------------------------------------------------
package mem_copy_engine_pkg;

  // Request type carried on the mode input.
  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage : mem_copy_engine_pkg

// File: rtl/ram_module_2port.sv
// -----------------------------------------------------------------------------
// ram_module_2port
// Simple dual-port RAM: one synchronous write port and one asynchronous
// (combinational) read port. Used as the memory that mem_copy_engine drives.
//
// Ports:
//   clk    in            write clock
//   wr     in            write enable, write happens on rising edge of clk
//   addr1  in  [AW-1:0]  write address
//   addr2  in  [AW-1:0]  read address
//   din    in  [Dbits-1:0] write data
//   dout2  out [Dbits-1:0] read data at addr2, combinational
// -----------------------------------------------------------------------------
module ram_module_2port #(
  parameter int Nloc  = 16,
  parameter int Dbits = 4,
  localparam int AW   = $clog2(Nloc)
) (
  input  logic             clk,
  input  logic             wr,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [Dbits-1:0] din,
  output logic [Dbits-1:0] dout2
);

  logic [Dbits-1:0] mem_q [Nloc];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[addr1] <= din;
    end
  end

  assign dout2 = mem_q[addr2];

endmodule : ram_module_2port

// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
// Single-request memory engine that either copies len words from src to dst
// (COPY) or writes a constant to len words starting at dst (FILL), one word
// per cycle, against a RAM with a synchronous write port and an asynchronous
// read port. Overlapping copies with src < dst run descending so the result
// behaves as a non-destructive move. Requests that would run past the end of
// memory are rejected without writing and flagged with err alongside done.
//
// Ports:
//   clock      in            rising-edge clock
//   reset_n    in            asynchronous active-low reset
//   start      in            request strobe, only honoured while idle
//   mode       in            0 = COPY, 1 = FILL
//   src        in  [AW-1:0]  source start address (COPY)
//   dst        in  [AW-1:0]  destination start address
//   len        in  [AW:0]    word count 0..Nloc
//   fill_val   in  [Dbits-1:0] constant written in FILL
//   busy       out           request in progress (RUN or FINISH)
//   done       out           one-cycle completion pulse
//   err        out           with done, marks a rejected request
//   ram_wr     out           RAM write enable
//   ram_addr1  out [AW-1:0]  RAM write address
//   ram_addr2  out [AW-1:0]  RAM read address
//   ram_din    out [Dbits-1:0] RAM write data
//   ram_dout2  in  [Dbits-1:0] RAM read data at ram_addr2 (combinational)
// -----------------------------------------------------------------------------
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int Nloc  = 16,
  parameter int Dbits = 4,
  localparam int AW   = $clog2(Nloc)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic [AW:0]      len,
  input  logic [Dbits-1:0] fill_val,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ram_wr,
  output logic [AW-1:0]    ram_addr1,
  output logic [AW-1:0]    ram_addr2,
  output logic [Dbits-1:0] ram_din,
  input  logic [Dbits-1:0] ram_dout2
);

  // Range arithmetic is done two bits wider than an address so that
  // dst+len (up to 2*Nloc-1 plus slack) never wraps.
  localparam int XW = AW + 2;

  state_e           state_q, state_d;
  mode_e            mode_q,  mode_d;
  logic             desc_q,  desc_d;
  logic             err_q,   err_d;
  logic [AW-1:0]    wa_q,    wa_d;     // current write (destination) address
  logic [AW-1:0]    ra_q,    ra_d;     // current read (source) address
  logic [AW:0]      cnt_q,   cnt_d;    // words still to write
  logic [Dbits-1:0] fill_q,  fill_d;

  // Request qualification on the live inputs, used only on the accept edge.
  logic [XW-1:0] src_x, dst_x, len_x, nloc_x;
  logic          req_copy;
  logic          req_oor;
  logic          req_overlap;
  logic [AW-1:0] wa_start;
  logic [AW-1:0] ra_start;

  assign src_x    = XW'(src);
  assign dst_x    = XW'(dst);
  assign len_x    = XW'(len);
  assign nloc_x   = XW'(Nloc);
  assign req_copy = (mode == MODE_COPY);

  assign req_oor = (dst_x + len_x > nloc_x) ||
                   (req_copy && (src_x + len_x > nloc_x));

  // A forward copy would overwrite source words before reading them only when
  // the destination starts strictly inside the source window.
  assign req_overlap = req_copy && (src_x < dst_x) && (dst_x < src_x + len_x);

  // Descending transfers start at the last word of each window. Only used for
  // in-range, non-empty requests, so the AW-bit result cannot wrap.
  assign wa_start = req_overlap ? (dst + AW'(len) - AW'(1)) : dst;
  assign ra_start = req_overlap ? (src + AW'(len) - AW'(1)) : src;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      desc_q  <= 1'b0;
      err_q   <= 1'b0;
      wa_q    <= '0;
      ra_q    <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      desc_q  <= desc_d;
      err_q   <= err_d;
      wa_q    <= wa_d;
      ra_q    <= ra_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    desc_d  = desc_q;
    err_d   = err_q;
    wa_d    = wa_q;
    ra_d    = ra_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          fill_d  = fill_val;
          desc_d  = req_overlap;
          wa_d    = wa_start;
          ra_d    = ra_start;
          cnt_d   = len;
          err_d   = req_oor;
          // Empty and rejected requests skip straight to the done pulse.
          state_d = (req_oor || (len == '0)) ? ST_FINISH : ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q - (AW+1)'(1);
        if (desc_q) begin
          wa_d = wa_q - AW'(1);
          ra_d = ra_q - AW'(1);
        end else begin
          wa_d = wa_q + AW'(1);
          ra_d = ra_q + AW'(1);
        end
        if (cnt_q == (AW+1)'(1)) begin
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded purely from the registered state so that an asserted
  // reset_n clears them without waiting for a clock edge. RAM buses are held
  // at zero whenever no write is in progress.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FINISH);
    err       = (state_q == ST_FINISH) && err_q;
    ram_wr    = (state_q == ST_RUN);
    ram_addr1 = '0;
    ram_addr2 = '0;
    ram_din   = '0;
    if (state_q == ST_RUN) begin
      ram_addr1 = wa_q;
      if (mode_q == MODE_COPY) begin
        // Read and write share the cycle: the asynchronous read data feeds
        // straight back out as write data.
        ram_addr2 = ra_q;
        ram_din   = ram_dout2;
      end else begin
        ram_din   = fill_q;
      end
    end
  end

endmodule : mem_copy_engine

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
// Drives mem_copy_engine connected to ram_module_2port. The bench can take
// over the RAM ports (tb_own) to preload and inspect memory while the engine
// is idle. Expected behaviour comes from a word-array model of memory and a
// list of expected writes derived from each request.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

  localparam int N  = 16;
  localparam int D  = 4;
  localparam int AW = 4;
  localparam int VW = 4 + AW + D;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [D-1:0]  fill_val;
  logic          busy;
  logic          done;
  logic          err;
  logic          ram_wr;
  logic [AW-1:0] ram_addr1;
  logic [AW-1:0] ram_addr2;
  logic [D-1:0]  ram_din;
  logic [D-1:0]  ram_dout2;

  // Bench-side access to the RAM while the engine is idle.
  logic          tb_own;
  logic          tb_wr;
  logic [AW-1:0] tb_waddr;
  logic [AW-1:0] tb_raddr;
  logic [D-1:0]  tb_wdata;

  int total = 0;
  int bad   = 0;

  logic [D-1:0] model [N];

  always #5 clock = ~clock;

  mem_copy_engine #(.Nloc(N), .Dbits(D)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill_val  (fill_val),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ram_wr    (ram_wr),
    .ram_addr1 (ram_addr1),
    .ram_addr2 (ram_addr2),
    .ram_din   (ram_din),
    .ram_dout2 (ram_dout2)
  );

  ram_module_2port #(.Nloc(N), .Dbits(D)) u_ram (
    .clk   (clock),
    .wr    (tb_own ? tb_wr    : ram_wr),
    .addr1 (tb_own ? tb_waddr : ram_addr1),
    .addr2 (tb_own ? tb_raddr : ram_addr2),
    .din   (tb_own ? tb_wdata : ram_din),
    .dout2 (ram_dout2)
  );

  // Write one word through the bench port and mirror it in the model.
  task automatic load_word(input int a, input logic [D-1:0] d);
    @(negedge clock);
    tb_own   = 1'b1;
    tb_wr    = 1'b1;
    tb_waddr = AW'(a);
    tb_wdata = d;
    @(negedge clock);
    tb_wr  = 1'b0;
    tb_own = 1'b0;
    model[a] = d;
  endtask

  // Compare every RAM word with the model (one comparison per call).
  task automatic check_mem(input string name);
    int nbad;
    int first;
    logic [D-1:0] got;
    logic [D-1:0] want;
    nbad  = 0;
    first = -1;
    got   = '0;
    want  = '0;
    tb_own = 1'b1;
    tb_wr  = 1'b0;
    for (int i = 0; i < N; i++) begin
      tb_raddr = AW'(i);
      #0.2;
      if (ram_dout2 !== model[i]) begin
        if (first < 0) begin
          first = i;
          got   = ram_dout2;
          want  = model[i];
        end
        nbad++;
      end
    end
    tb_own = 1'b0;
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s memory: %0d words differ, first at %0d got=%h want=%h",
               name, nbad, first, got, want);
    end
  endtask

  // Issue one request and check the engine cycle by cycle against the
  // expected write list, then check the resulting memory image.
  task automatic run_req(input string name, input bit m, input int s, input int d,
                         input int l, input logic [D-1:0] fv, input bit poke);
    logic [D-1:0] old [N];
    int           ea [$];
    int           er [$];
    logic [D-1:0] ed [$];
    bit           oor;
    bit           desc;
    int           nw;
    int           i;
    logic [VW-1:0] exp_v;
    logic [VW-1:0] act_v;

    oor  = (d + l > N) || (m == 1'b0 && s + l > N);
    nw   = (oor || l == 0) ? 0 : l;
    desc = (m == 1'b0) && (s < d) && (d < s + l);
    old  = model;
    for (int k = 0; k < nw; k++) begin
      i = desc ? (nw - 1 - k) : k;
      ea.push_back(d + i);
      er.push_back(s + i);
      ed.push_back(m ? fv : old[s + i]);
    end
    // A move: every destination word takes the pre-request source word.
    for (int k = 0; k < nw; k++) model[ea[k]] = ed[k];

    $display("txn %s mode=%0d src=%0d dst=%0d len=%0d fill=%h oor=%0d desc=%0d",
             name, m, s, d, l, fv, oor, desc);

    @(negedge clock);
    start    = 1'b1;
    mode     = m;
    src      = AW'(s);
    dst      = AW'(d);
    len      = (AW+1)'(l);
    fill_val = fv;
    @(negedge clock);
    // Scramble the request inputs: the engine must use its latched copy.
    start    = 1'b0;
    mode     = 1'($urandom);
    src      = AW'($urandom);
    dst      = AW'($urandom);
    len      = (AW+1)'($urandom);
    fill_val = D'($urandom);

    for (int cyc = 1; cyc <= nw + 2; cyc++) begin
      act_v = {busy, done, err, ram_wr, ram_addr1, ram_din};
      if (cyc <= nw) begin
        exp_v = {1'b1, 1'b0, 1'b0, 1'b1, AW'(ea[cyc-1]), ed[cyc-1]};
      end else if (cyc == nw + 1) begin
        exp_v = {1'b1, 1'b1, oor, 1'b0, {AW{1'b0}}, {D{1'b0}}};
      end else begin
        exp_v = '0;
      end
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d {busy,done,err,wr,addr1,din} got=%h want=%h",
                 name, cyc, act_v, exp_v);
      end
      // Read address must track the source word during COPY writes, and be
      // parked at zero whenever no write happens.
      if (cyc > nw || m == 1'b0) begin
        total++;
        if (ram_addr2 !== ((cyc <= nw) ? AW'(er[cyc-1]) : AW'(0))) begin
          bad++;
          $display("FAIL %s cyc=%0d addr2 got=%0d want=%0d", name, cyc, ram_addr2,
                   (cyc <= nw) ? er[cyc-1] : 0);
        end
      end
      // A start pulse while busy must neither restart nor queue a request.
      start = poke && (cyc == 1);
      @(negedge clock);
    end
    start = 1'b0;
    check_mem(name);
  endtask

  task automatic load_random;
    for (int a = 0; a < N; a++) load_word(a, D'($urandom));
  endtask

  task automatic test_reset;
    logic [VW+AW-1:0] v;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    v = {busy, done, err, ram_wr, ram_addr1, ram_addr2, ram_din};
    $display("txn reset outputs=%h", v);
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL reset outputs got=%h want=0", v);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_fill_basic;
    load_random();
    run_req("fill_basic", 1'b1, 0, 3, 4, 4'hA, 1'b0);
  endtask

  task automatic test_copy_fwd;
    load_random();
    for (int a = 0; a < 4; a++) load_word(a, D'(a + 1));
    run_req("copy_fwd", 1'b0, 0, 8, 4, 4'h0, 1'b0);
  endtask

  task automatic test_copy_overlap;
    load_random();
    for (int a = 0; a < 6; a++) load_word(a, D'(a + 1));
    run_req("copy_overlap", 1'b0, 0, 2, 4, 4'h0, 1'b1);
  endtask

  task automatic test_range;
    run_req("fill_oor",   1'b1, 0, 14, 4, 4'h5, 1'b0);
    run_req("fill_len0",  1'b1, 0, 5, 0, 4'h6, 1'b1);
    run_req("copy_srcoor", 1'b0, 12, 0, 5, 4'h0, 1'b0);
    run_req("fill_full",  1'b1, 0, 0, 16, 4'h3, 1'b0);
    load_random();
    run_req("copy_edge",  1'b0, 0, 12, 4, 4'h0, 1'b0);
    run_req("copy_over_len", 1'b0, 0, 0, 17, 4'h0, 1'b0);
  endtask

  task automatic test_reset_midrun;
    logic [D-1:0] fv;
    logic [2:0]   v;
    fv = 4'h9;
    for (int a = 0; a < 8; a++) load_word(a, ~fv);
    $display("txn reset_midrun fill dst=0 len=8 fill=%h", fv);
    @(negedge clock);
    start = 1'b1; mode = 1'b1; src = '0; dst = '0; len = 5'd8; fill_val = fv;
    @(negedge clock);             // cycle 1: write 0
    start = 1'b0;
    @(negedge clock);             // cycle 2: write 1, second start pulse
    start = 1'b1; dst = 4'd9; len = 5'd2;
    @(negedge clock);             // cycle 3: write 2 presented
    start = 1'b0;
    total++;
    if ({ram_wr, ram_addr1} !== {1'b1, 4'd2}) begin
      bad++;
      $display("FAIL reset_midrun third write {wr,addr1} got=%h want=%h",
               {ram_wr, ram_addr1}, {1'b1, 4'd2});
    end
    reset_n = 1'b0;
    #1;
    v = {ram_wr, busy, done};
    total++;
    if (v !== 3'b000) begin
      bad++;
      $display("FAIL reset_midrun immediate {wr,busy,done} got=%b want=000", v);
    end
    model[0] = fv;
    model[1] = fv;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      total++;
      if ({ram_wr, busy, done, err} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_midrun held c=%0d {wr,busy,done,err} got=%b want=0000",
                 c, {ram_wr, busy, done, err});
      end
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      total++;
      if ({ram_wr, busy, done} !== 3'b000) begin
        bad++;
        $display("FAIL reset_midrun after {wr,busy,done} got=%b want=000",
                 {ram_wr, busy, done});
      end
    end
    check_mem("reset_midrun");
  endtask

  task automatic test_random;
    int s, d, l;
    bit m;
    load_random();
    for (int t = 0; t < 30; t++) begin
      m = 1'($urandom);
      s = $urandom_range(0, N - 1);
      d = $urandom_range(0, N - 1);
      case ($urandom_range(0, 3))
        0: l = $urandom_range(0, N + 2);
        1: begin  // forced overlapping move
          l = $urandom_range(2, 8);
          s = $urandom_range(0, N - l - 1);
          d = s + $urandom_range(1, l - 1);
          m = 1'b0;
        end
        default: l = $urandom_range(0, N - ((s > d) ? s : d));
      endcase
      run_req($sformatf("rand%0d", t), m, s, d, l, D'($urandom), 1'($urandom));
    end
  endtask

  // Requests issued the cycle after the previous one goes idle.
  task automatic test_back_to_back;
    run_req("b2b_a", 1'b1, 0, 4, 3, 4'hC, 1'b0);
    run_req("b2b_b", 1'b0, 4, 5, 3, 4'h0, 1'b0);
    run_req("b2b_c", 1'b0, 6, 1, 5, 4'h0, 1'b1);
  endtask

  initial begin
    start    = 1'b0;
    mode     = 1'b0;
    src      = '0;
    dst      = '0;
    len      = '0;
    fill_val = '0;
    tb_own   = 1'b0;
    tb_wr    = 1'b0;
    tb_waddr = '0;
    tb_raddr = '0;
    tb_wdata = '0;
    for (int a = 0; a < N; a++) model[a] = '0;

    test_reset();
    test_fill_basic();
    test_copy_fwd();
    test_copy_overlap();
    test_range();
    test_reset_midrun();
    test_back_to_back();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_copy_engine
